wta_spi_host: RTL

Host-side SPI frame engine for the WTA/PWM tile's clock-synchronous serial link (no SCLK: one bit per `clk` cycle while `SS` is low). It sits in the test/companion wrapper and drives the tile's `ss`/`mosi` inputs while capturing `miso`. It loads 96-bit pulse-width frames into the tile and reads back 96-bit count frames or 16-bit `{knn, nn}` result frames. Frame length, select set-up/hold and MISO return latency are fixed protocol parameters.

---
 rtl/wta_spi_pkg.sv | 16 +
 rtl/wta_spi_host.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wta_spi_pkg.sv
// Shared types and frame constants for the WTA/PWM tile serial link.
package wta_spi_pkg;

    localparam int WTA_FRAME1_W = 96;
    localparam int WTA_FRAME2_W = 16;
    localparam int WTA_LEN_W    = 7;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        TAIL,
        DONE
    } spi_state_t;

endpackage

// File: rtl/wta_spi_host.sv
// Host-side frame engine: shifts a right-aligned payload out on mosi (one bit
// per clk while ss is low) and captures the slave's delayed miso stream.
//
// state | meaning
// IDLE  | ss high, waiting for a legal start
// SETUP | ss low, select set-up before the first data bit
// SHIFT | ss low, one payload bit per cycle on mosi
// TAIL  | ss low, waiting for the last miso bits to return
// DONE  | ss high, done pulse, rx data valid
module wta_spi_host
    import wta_spi_pkg::*;
#(
    parameter int FRAME_W   = WTA_FRAME1_W,
    parameter int SETUP_CYC = 1,
    parameter int MISO_DLY  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WTA_LEN_W-1:0] i_len,
    input  logic [FRAME_W-1:0]   i_tx_data,
    output logic                 o_ss,
    output logic                 o_mosi,
    input  logic                 i_miso,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [FRAME_W-1:0]   o_rx_data
);

    localparam logic [WTA_LEN_W-1:0] MAX_LEN  = WTA_LEN_W'(FRAME_W);
    localparam logic [2:0]           SETUP_LD = 3'(SETUP_CYC - 1);
    localparam logic [2:0]           TAIL_LD  = 3'((MISO_DLY > 0) ? MISO_DLY - 1 : 0);

    spi_state_t             state_q, state_d;
    logic                   accept, len_ok, in_shift, cap_en, err_q;
    logic [WTA_LEN_W-1:0]   bit_cnt_q, sh_amt;
    logic [2:0]             ph_cnt_q;
    logic [FRAME_W-1:0]     tx_sh_q, rx_sh_q, rx_nxt, tx_load;

    assign len_ok   = (i_len != '0) && (i_len <= MAX_LEN);
    assign in_shift = (state_q == SHIFT);
    assign sh_amt   = MAX_LEN - i_len;
    // Left-justify the payload so bit i_len-1 sits at the shift register MSB.
    assign tx_load  = i_tx_data << sh_amt;
    assign rx_nxt   = cap_en ? FRAME_W'({rx_sh_q, i_miso}) : rx_sh_q;
    assign o_err    = err_q;

    // Capture window is the SHIFT window delayed by the miso return latency.
    if (MISO_DLY == 0) begin : g_no_dly
        assign cap_en = in_shift;
    end else begin : g_dly
        logic [MISO_DLY-1:0] vld_q;
        always_ff @(posedge clk) begin
            if (!rst_n) vld_q <= '0;
            else        vld_q <= MISO_DLY'({vld_q, in_shift});
        end
        assign cap_en = vld_q[MISO_DLY-1];
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        o_ss    = 1'b0;
        o_mosi  = 1'b0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ss   = 1'b1;
                o_busy = 1'b0;
                if (i_start && len_ok) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: if (ph_cnt_q == '0) state_d = SHIFT;
            SHIFT: begin
                o_mosi = tx_sh_q[FRAME_W-1];
                if (bit_cnt_q == '0) state_d = (MISO_DLY == 0) ? DONE : TAIL;
            end
            TAIL:  if (ph_cnt_q == '0) state_d = DONE;
            DONE: begin
                o_ss    = 1'b1;
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ph_cnt_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            o_rx_data <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && i_start && !len_ok;
            if (accept) begin
                tx_sh_q   <= tx_load;
                rx_sh_q   <= '0;
                o_rx_data <= '0;
                bit_cnt_q <= i_len - WTA_LEN_W'(1);
                ph_cnt_q  <= SETUP_LD;
            end else begin
                rx_sh_q <= rx_nxt;
                // Include the bit sampled on the final capture cycle.
                if (state_d == DONE && state_q != DONE) o_rx_data <= rx_nxt;
                case (state_q)
                    SETUP: if (ph_cnt_q != '0) ph_cnt_q <= ph_cnt_q - 3'd1;
                    SHIFT: begin
                        tx_sh_q <= tx_sh_q << 1;
                        if (bit_cnt_q != '0) bit_cnt_q <= bit_cnt_q - WTA_LEN_W'(1);
                        else                 ph_cnt_q  <= TAIL_LD;
                    end
                    TAIL:  if (ph_cnt_q != '0) ph_cnt_q <= ph_cnt_q - 3'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
